// File: rtl/dec4_to_16.sv
// Registered 4-to-16 one-hot decoder with active-high enable.
// Two-level 2-to-4 decoder tree feeding a 16-bit output register with synchronous clear.
module dec4_to_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        En,
    input  logic [3:0]  W,
    output logic [0:15] Y
);

    // Bit k of the result is high iff en is high and sel equals k.
    function automatic logic [0:3] dec2to4(input logic en, input logic [1:0] sel);
        logic [0:3] out;
        out = '0;
        out[sel] = en;
        return out;
    endfunction

    logic [0:3]  w_grp_en;
    logic [0:15] w_lines;
    logic [0:15] r_y;

    // First level selects one group of four lines from the upper select bits.
    assign w_grp_en = dec2to4(En, W[3:2]);

    for (genvar g = 0; g < 4; g++) begin : g_leaf
        assign w_lines[g*4 +: 4] = dec2to4(w_grp_en[g], W[1:0]);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= '0;
        end else begin
            r_y <= w_lines;
        end
    end

    assign Y = r_y;

endmodule

// File: tb/tb_dec4_to_16.sv
// Self-checking bench for dec4_to_16: directed vector table, glitch sequence,
// randomized stimulus against an index-based reference model, and a per-cycle one-hot invariant.
module tb_dec4_to_16;

    logic        clk;
    logic        rst;
    logic        En;
    logic [3:0]  W;
    logic [0:15] Y;

    int n_vec = 0;
    int n_bad = 0;

    dec4_to_16 dut (
        .clk (clk),
        .rst (rst),
        .En  (En),
        .W   (W),
        .Y   (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  w;
        logic [0:15] y;
    } vec_t;

    task automatic check(input string name, input logic [0:15] act, input logic [0:15] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: Y=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the selected line is simply the line whose index equals W.
    function automatic logic [0:15] model(input logic r, input logic e, input logic [3:0] w);
        logic [0:15] y;
        y = '0;
        if (!r && e) y[int'(w)] = 1'b1;
        return y;
    endfunction

    // Apply one cycle of inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic r, input logic e, input logic [3:0] w);
        @(negedge clk);
        rst = r;
        En  = e;
        W   = w;
        @(posedge clk);
        #1;
    endtask

    // Invariant monitor: one line high exactly when the previous edge decoded with En=1.
    logic started = 1'b0;
    logic p_rst, p_en;
    always @(posedge clk) begin
        p_rst <= rst;
        p_en  <= En;
        if (rst) started <= 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            n_vec++;
            if ($countones(Y) != ((!p_rst && p_en) ? 1 : 0)) begin
                n_bad++;
                $display("FAIL onehot_invariant: Y=%h prev_rst=%b prev_en=%b at %0t",
                         Y, p_rst, p_en, $time);
            end
        end
    end

    vec_t vecs[$];

    initial begin
        rst = 1'b1;
        En  = 1'b1;
        W   = 4'h5;

        // Directed table; expected words written with Y[0] as the leftmost bit.
        vecs = '{
            '{1'b1, 1'b1, 4'h5, 16'h0000},  // reset, first edge
            '{1'b1, 1'b1, 4'h5, 16'h0000},  // reset, second edge
            '{1'b0, 1'b1, 4'h5, 16'h0400},  // release -> Y[5]
            '{1'b0, 1'b1, 4'h0, 16'h8000},  // Y[0]
            '{1'b0, 1'b1, 4'hB, 16'h0010},  // Y[11]
            '{1'b0, 1'b1, 4'hF, 16'h0001},  // Y[15]
            '{1'b0, 1'b1, 4'h1, 16'h4000},  // Y[1]
            '{1'b0, 1'b1, 4'h2, 16'h2000},  // Y[2]
            '{1'b0, 1'b1, 4'h8, 16'h0080},  // Y[8]
            '{1'b0, 1'b0, 4'hC, 16'h0000},  // disabled
            '{1'b0, 1'b0, 4'hD, 16'h0000},
            '{1'b0, 1'b0, 4'hE, 16'h0000},
            '{1'b0, 1'b1, 4'hE, 16'h0002},  // re-enable -> Y[14]
            '{1'b0, 1'b1, 4'h7, 16'h0100},  // Y[7]
            '{1'b1, 1'b1, 4'h7, 16'h0000},  // reset priority over En/W
            '{1'b0, 1'b0, 4'h7, 16'h0000},  // rst and En drop together
            '{1'b1, 1'b1, 4'h9, 16'h0000},  // rst and En rise together
            '{1'b0, 1'b1, 4'h3, 16'h1000}   // Y[3]
        };

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].w);
            check($sformatf("table[%0d]", i), Y, vecs[i].y);
        end

        // Exhaustive enabled sweep.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 4'(i));
            check($sformatf("sweep_w%0d", i), Y, model(1'b0, 1'b1, 4'(i)));
        end

        // Glitch: W wanders to 9 and back between edges; only the edge value matters.
        step(1'b0, 1'b1, 4'h3);
        check("glitch_pre", Y, 16'h1000);
        @(negedge clk);
        W = 4'h9;
        #2;
        check("glitch_mid", Y, 16'h1000);
        W = 4'h3;
        @(posedge clk);
        #1;
        check("glitch_post", Y, 16'h1000);

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic r, e;
            logic [3:0] w;
            r = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 3) != 0);
            w = 4'($urandom);
            step(r, e, w);
            check($sformatf("random[%0d]", i), Y, model(r, e, w));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dec4_to_16.md
Name: dec4_to_16

Overview:
- Registered 4-to-16 one-hot decoder with active-high enable.
- A 4-bit select code W drives exactly one of 16 output lines when enabled; all outputs are low when disabled.
- Used as a generic address/select decoder; the output is registered so it feeds downstream synchronous logic directly.

Parameters:
- None. Widths are fixed: 4-bit input, 16-bit output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- En   input  1  decode enable, active-high
- W    input  4  select code, W[3] MSB, W[0] LSB
- Y    output 16  one-hot decoded output, declared [0:15]; bit Y[i] corresponds to code value i

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, Y <= 16'b0 (all lines low). rst has priority over En and W.
- Decode rule, evaluated at each rising clk edge with rst=0:
  - next Y[i] = 1 iff En=1 and unsigned(W) == i, for i = 0..15;
  - all other bits = 0.
- Enable low: with En=0 the next Y is all zeros regardless of W.
- Output is one-hot or all-zero; never more than one bit set.
- Latency: exactly 1 clock. W/En sampled at edge k appear on Y after edge k; Y holds between edges.
- Bit ordering:
  - Y[0] is the leftmost bit of the [0:15] vector and is asserted for W=4'b0000;
  - Y[15] is asserted for W=4'b1111;
  - W=4'b0001 (W[0]=1 only) selects Y[1];
  - W=4'b0010 selects Y[2];
  - W=4'b1000 selects Y[8].
- Internal structure:
  - two-level tree: one 2-to-4 decoder on W[3:2], gated by En, drives the enables of four 2-to-4 decoders on W[1:0];
  - the 16 decoded lines feed a 16-bit output register with synchronous clear.
- Power-up before the first reset: Y undefined (X in simulation); no requirement until rst has been applied for at least one edge.
- Input changes between edges have no effect on Y. Only the value present at the rising edge matters; no combinational path from W/En to Y.
- Reset asserted mid-operation: Y clears on the next edge. Decoding resumes on the first edge with rst=0, using the W/En present at that edge.

Test Plan:
- Reset:
  - stimulus: rst=1, En=1, W=4'h5 for 2 edges;
  - response: Y=16'b0 after each edge; rst then 0 with W=4'h5 -> after the next edge Y[5]=1, all others 0.
- Exhaustive enabled sweep:
  - stimulus: En=1, W=0..15, one value per cycle;
  - response: one cycle later Y[W]=1 and the other 15 bits 0. Spot checks: W=0 -> Y[0]; W=4'b1011 -> Y[11]; W=4'hF -> Y[15].
- Disable:
  - stimulus: En=0 with W=12, 13, 14;
  - response: Y=16'b0 after each edge; re-assert En=1 with W=14 -> Y[14]=1 after the next edge.
- Latency/glitch:
  - stimulus: change W from 3 to 9 mid-cycle, then back to 3 before the edge;
  - response: Y stays one-hot at Y[3] across the edge; Y[9] is never asserted.
- Reset priority:
  - stimulus: rst=1 asserted while En=1, W=7 and Y[7]=1;
  - response: Y=0 after the edge. Also check that rst and En toggling in the same cycle yields all-zero Y.
- Invariant (assertion, every cycle): popcount(Y) <= 1, and popcount(Y)==1 iff the previous edge had rst=0 and En=1.
